// File: rtl/wb_master_arbiter.sv
// Purpose : round-robin arbiter sharing one Wishbone master port between
//           NUM_MASTERS requesters; a grant is held for a whole CYC tenure.
// Latency : grant 1 cycle after CYC; s_* mux, ack and read data are combinational.
// Backpressure: losers wait with CYC high; an unacked STB is ended by an err
//           pulse after TIMEOUT cycles (0 disables the timeout).
// Ports   : m_*_i/m_*_o  packed per-master request bundles and replies
//           s_*_o/s_*_i  single master port towards the interconnect
//           grant_o      one-hot current owner, 0 when idle
module wb_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [31:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               s_dat_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Keep at least one counter bit so TIMEOUT=0 still elaborates cleanly.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  gnt_q, gnt_d;
  logic [IW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IW-1:0]  pick;
  logic [IW-1:0]  idx_w;
  logic           found;
  logic           busy;
  logic           g_cyc;
  logic           g_stb;
  logic           tmo_hit;

  assign busy  = (state_q == BUSY);
  assign g_cyc = m_cyc_i[gnt_q];
  assign g_stb = m_stb_i[gnt_q];
  // Ack in the same cycle as the compare wins, so the hit needs s_ack_i low.
  assign tmo_hit = busy && (TIMEOUT > 0) && (cnt_q == TMO) && g_stb && !s_ack_i;

  assign m_dat_o = s_dat_i;

  // Round-robin pick: first requester after last_q, wrapping around, so the
  // previous owner is chosen again only when nobody else is asking.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx_w = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx_w = IW'((int'(last_q) + k) % NUM_MASTERS);
      if (!found && m_cyc_i[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = pick;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          last_d  = gnt_q;
        end else if ((TIMEOUT > 0) && g_stb && !s_ack_i && !tmo_hit) begin
          // tmo_hit covers cnt_q == TMO, so the counter stops there.
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: everything is quiet unless a tenure is in progress.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    grant_o = '0;
    if (busy) begin
      s_cyc_o        = g_cyc;
      s_stb_o        = g_stb && !tmo_hit;
      s_we_o         = m_we_i[gnt_q];
      s_adr_o        = m_adr_i[32*gnt_q +: 32];
      s_dat_o        = m_dat_i[32*gnt_q +: 32];
      s_sel_o        = m_sel_i[4*gnt_q +: 4];
      m_ack_o[gnt_q] = s_ack_i && g_stb;
      m_err_o[gnt_q] = tmo_hit;
      grant_o[gnt_q] = 1'b1;
    end
  end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Round-robin arbiter that shares the single Wishbone master port of intercon_wb between NUM_MASTERS requesters, e.g. CPU instruction fetch and data load/store.
- Sits between the masters and the intercon master_* ports.
- Holds a grant for a whole CYC tenure.
- Terminates stalled accesses with an error pulse after a programmable timeout.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT, 255, cycles STB may stay unacknowledged before an error is issued; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_dat_i  in  32*NUM_MASTERS  write data; master k in bits [32k+31:32k].
- m_we_i  in  NUM_MASTERS  write enable per master.
- m_sel_i  in  4*NUM_MASTERS  byte selects; master k in bits [4k+3:4k].
- m_adr_i  in  32*NUM_MASTERS  addresses; master k in bits [32k+31:32k].
- m_cyc_i  in  NUM_MASTERS  cycle request per master.
- m_stb_i  in  NUM_MASTERS  strobe per master.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o  out  NUM_MASTERS  acknowledge, one-hot to the granted master.
- m_err_o  out  NUM_MASTERS  timeout error pulse to the granted master.
- s_dat_o  out  32  to intercon master_dat_i.
- s_we_o  out  1  to intercon master_we_i.
- s_sel_o  out  4  to intercon master_sel_i.
- s_adr_o  out  32  to intercon master_adr_i.
- s_cyc_o  out  1  to intercon master_cyc_i.
- s_stb_o  out  1  to intercon master_stb_i.
- s_dat_i  in  32  from intercon master_dat_o.
- s_ack_i  in  1  from intercon master_ack_o.
- grant_o  out  NUM_MASTERS  one-hot current grant; 0 when idle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE, grant 0, last_grant = NUM_MASTERS-1 so master 0 has first priority, timeout counter 0.
  - All s_* outputs, m_ack_o, m_err_o and grant_o are 0 immediately.
- m_dat_o = s_dat_i at all times, combinational.
- State IDLE:
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o are all 0.
  - If any m_cyc_i is set, pick the first requester scanning from last_grant+1 with wrap-around.
  - Register the choice in grant and go to BUSY on the next clk edge.
  - Grant latency is 1 cycle from CYC assertion.
- State BUSY, granted master g:
  - s_* outputs mux combinationally from master g.
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_stb_i[g].
  - m_ack_o[g] = s_ack_i & m_stb_i[g]; all other m_ack_o bits are 0.
  - Non-granted masters see no ack or err and simply wait.
- Release:
  - When m_cyc_i[g] is sampled 0 at a clk edge: last_grant <= g, go to IDLE.
  - s_cyc_o falls in the same cycle as m_cyc_i[g], combinationally.
  - Exactly one IDLE cycle separates consecutive tenures.
  - The next grant goes to the next requester after g; g itself is served again only if it is the sole requester.
- Timeout (TIMEOUT>0):
  - Counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - Counter clears on s_ack_i, on s_stb_o=0, and on leaving BUSY.
  - When the counter equals TIMEOUT, m_err_o[g]=1 for exactly that cycle; s_stb_o is forced 0 that cycle; the counter clears.
  - The master must then drop or retry STB.
- Simultaneous events:
  - s_ack_i in the same cycle the counter reaches TIMEOUT: ack wins, no error.
  - s_ack_i while in IDLE, or while m_stb_i[g]=0: ignored, no ack forwarded.
  - Several masters requesting in the same IDLE cycle: the round-robin order above decides.
- Reset asserted mid-transaction: outputs drop to 0 immediately; no ack or err is produced for the aborted access.
- Counter width is $clog2(TIMEOUT+1); it saturates at the compare and never wraps.

Test Plan:
- Single master, write: m0 cyc/stb/we=1, adr=0x00100000, dat=0xFFFFFFFF, sel=0xF; slave ack the cycle after s_stb_o -> grant_o=01 one cycle after request; s_adr_o=0x00100000, s_dat_o=0xFFFFFFFF; m_ack_o=01 same cycle as s_ack_i.
- Contention:
  - Stimulus: m0 and m1 assert cyc in the same cycle out of reset.
  - Required: m0 granted first; on m0 cyc drop, one IDLE cycle, then grant_o=10.
  - Required: while m0 holds the bus, m1 receives no ack even when s_ack_i=1.
- Fairness: both masters request continuously for 4 tenures -> grant sequence 01,10,01,10; no master gets two consecutive tenures.
- Read data: m1 granted, s_dat_i=0xDEADBEEF with s_ack_i=1 -> m_dat_o=0xDEADBEEF, m_ack_o=10, m_err_o=00.
- Timeout: TIMEOUT=4, m0 stb held, s_ack_i never asserted -> m_err_o=01 for one cycle when the counter hits 4, s_stb_o=0 that cycle. Repeat with s_ack_i arriving in that same cycle -> ack, no err.
- Reset mid-cycle: pull rst_n low while s_cyc_o=1 -> s_cyc_o, s_stb_o, grant_o = 0 without waiting for clk; after release, m0 is granted first.
